restoring_div8x4: RTL and testbench

RESTORING_DIV8X4 -- requirements
Module: restoring_div8x4

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_step.sv | 25 ++
 rtl/restoring_div8x4.sv | 172 +++++++++++++++++
 tb/tb_restoring_div8x4.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the restoring divider: FSM states,
// default operand width and the number of restoring iterations.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    localparam int DIV_N     = 4;
    localparam int DIV_ITERS = 2 * DIV_N;

    // Each dividend bit costs one restoring iteration.
    function automatic int iter_count(input int n);
        return 2 * n;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference if it is non-negative.
module div_step #(
    parameter int W = 9
) (
    input  logic [W-1:0] prem,
    input  logic [W-1:0] dvsr,
    input  logic         next_bit,
    output logic [W-1:0] new_rem,
    output logic         q_bit
);

    logic [W-1:0] shifted;
    logic [W:0]   diff;

    // A bit shifted out of the top means the true value exceeds any divisor,
    // and the modulo-2^W difference is still the correct new remainder.
    always_comb begin
        shifted = {prem[W-2:0], next_bit};
        diff    = {1'b0, shifted} - {1'b0, dvsr};
        q_bit   = prem[W-1] | ~diff[W];
        new_rem = q_bit ? diff[W-1:0] : shifted;
    end

endmodule

// File: rtl/restoring_div8x4.sv
// Multi-cycle restoring divider, 2N-bit dividend by N-bit divisor, fixed latency.
// Define DIV_SIGNED_EN for two's-complement operands; the default build is unsigned.
module restoring_div8x4
    import div_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           ovf,
    output logic           dbz
);

    localparam int QW    = 2 * N;
    localparam int W     = 2 * N + 1;
    localparam int ITERS = iter_count(N);
    localparam int CW    = $clog2(ITERS);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [QW-1:0]   dvd_mag;
    logic [QW-1:0]   quo;
    logic [W-1:0]    dvs_mag;
    logic [W-1:0]    prem;

    logic [W-1:0]    step_rem;
    logic            step_q;

    logic [QW-1:0]   in_dvd_mag;
    logic [N-1:0]    in_dvs_mag;

    logic            range_bad;
    logic [N-1:0]    q_val;
    logic [N-1:0]    r_val;
    logic            fix_dbz;
    logic            fix_ovf;
    logic [N-1:0]    fix_quo;
    logic [N-1:0]    fix_rem;

    div_step #(
        .W(W)
    ) u_step (
        .prem     (prem),
        .dvsr     (dvs_mag),
        .next_bit (dvd_mag[QW-1]),
        .new_rem  (step_rem),
        .q_bit    (step_q)
    );

`ifdef DIV_SIGNED_EN
    localparam logic [QW-1:0] NEG_LIM = QW'(2 ** (N - 1));
    localparam logic [QW-1:0] POS_LIM = QW'(2 ** (N - 1) - 1);

    logic in_neg_q;
    logic in_neg_r;
    logic neg_q;
    logic neg_r;

    // Negating the most negative value wraps back to its own bit pattern,
    // which read as unsigned is exactly the wanted magnitude.
    always_comb begin
        in_neg_r   = dividend[QW-1];
        in_neg_q   = dividend[QW-1] ^ divisor[N-1];
        in_dvd_mag = dividend[QW-1] ? -dividend : dividend;
        in_dvs_mag = divisor[N-1] ? -divisor : divisor;
    end

    always_comb begin
        range_bad = quo > (neg_q ? NEG_LIM : POS_LIM);
        q_val     = neg_q ? -quo[N-1:0] : quo[N-1:0];
        r_val     = neg_r ? -prem[N-1:0] : prem[N-1:0];
    end
`else
    always_comb begin
        in_dvd_mag = dividend;
        in_dvs_mag = divisor;
    end

    always_comb begin
        range_bad = |quo[QW-1:N];
        q_val     = quo[N-1:0];
        r_val     = prem[N-1:0];
    end
`endif

    // NOTE: every output of an always_comb block is assigned on every path,
    // so no latch can be inferred for the FIX-stage results.
    always_comb begin
        fix_dbz = (dvs_mag == '0);
        fix_ovf = !fix_dbz && range_bad;
        fix_quo = (fix_dbz || range_bad) ? '0 : q_val;
        fix_rem = (fix_dbz || range_bad) ? '0 : r_val;
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the values from before this edge, regardless of order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            dvd_mag   <= '0;
            dvs_mag   <= '0;
            prem      <= '0;
            quo       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            ovf       <= 1'b0;
            dbz       <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= CALC;
                        cnt       <= '0;
                        dvd_mag   <= in_dvd_mag;
                        dvs_mag   <= W'(in_dvs_mag);
                        prem      <= '0;
                        quo       <= '0;
                        busy      <= 1'b1;
                        quotient  <= '0;
                        remainder <= '0;
                        ovf       <= 1'b0;
                        dbz       <= 1'b0;
`ifdef DIV_SIGNED_EN
                        neg_q     <= in_neg_q;
                        neg_r     <= in_neg_r;
`endif
                    end
                end
                CALC: begin
                    prem    <= step_rem;
                    quo     <= {quo[QW-2:0], step_q};
                    dvd_mag <= {dvd_mag[QW-2:0], 1'b0};
                    cnt     <= cnt + 1'b1;
                    if (cnt == CW'(ITERS - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    quotient  <= fix_quo;
                    remainder <= fix_rem;
                    ovf       <= fix_ovf;
                    dbz       <= fix_dbz;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_div8x4.sv
// Directed self-checking bench for restoring_div8x4; covers the unsigned
// build by default and the signed build when DIV_SIGNED_EN is defined.
module tb_restoring_div8x4;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       ovf;
    logic       dbz;

    int total;
    int fails;

    restoring_div8x4 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .ovf       (ovf),
        .dbz       (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start with the given operands and wait (bounded) for done.
    // lat is the cycle of the done pulse, -1 on timeout; returns in IDLE.
    task automatic run_div(input logic [7:0] dvd, input logic [3:0] dvs,
                           output int lat, output logic busy_mid);
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        lat      = -1;
        busy_mid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            if (c == 5) busy_mid = busy;
            if (done) begin
                lat = c;
                break;
            end
        end
        tick();
    endtask

    task automatic check_result(input string tag, input int lat,
                                input logic [3:0] q, input logic [3:0] r,
                                input logic v, input logic z);
        check({tag, "_lat"}, lat, 10);
        check({tag, "_quo"}, {28'd0, quotient}, {28'd0, q});
        check({tag, "_rem"}, {28'd0, remainder}, {28'd0, r});
        check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, v});
        check({tag, "_dbz"}, {31'd0, dbz}, {31'd0, z});
    endtask

    initial begin
        int   lat;
        logic bm;
        int   n_done;
        int   d1;
        int   d2;
        logic [3:0] q1;
        logic [3:0] r1;
        logic [3:0] q2;
        logic [3:0] r2;
        logic seen_done;

        total    = 0;
        fails    = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_quo", {28'd0, quotient}, 32'd0);
        check("rst_flags", {30'd0, ovf, dbz}, 32'd0);
        rst_n = 1'b1;

`ifdef DIV_SIGNED_EN
        run_div(8'hEC, 4'h3, lat, bm);        // -20 / 3
        check("s_m20_3_busy", {31'd0, bm}, 32'd1);
        check("s_m20_3_done_len", {31'd0, done}, 32'd0);
        check_result("s_m20_3", lat, 4'hA, 4'hE, 1'b0, 1'b0);
        run_div(8'hC8, 4'h8, lat, bm);        // -56 / -8
        check_result("s_m56_m8", lat, 4'h7, 4'h0, 1'b0, 1'b0);
        run_div(8'd100, 4'h3, lat, bm);       // 100 / 3 = 33
        check_result("s_100_3", lat, 4'h0, 4'h0, 1'b1, 1'b0);
        run_div(8'h80, 4'h8, lat, bm);        // -128 / -8 = 16
        check_result("s_m128_m8", lat, 4'h0, 4'h0, 1'b1, 1'b0);
        run_div(8'h40, 4'h8, lat, bm);        // 64 / -8 = -8, edge of range
        check_result("s_64_m8", lat, 4'h8, 4'h0, 1'b0, 1'b0);
        run_div(8'h07, 4'hE, lat, bm);        // 7 / -2 = -3 rem 1
        check_result("s_7_m2", lat, 4'hD, 4'h1, 1'b0, 1'b0);
`else
        run_div(8'd200, 4'd13, lat, bm);
        check("u_200_13_busy", {31'd0, bm}, 32'd1);
        check("u_200_13_done_len", {31'd0, done}, 32'd0);
        check_result("u_200_13", lat, 4'd15, 4'd5, 1'b0, 1'b0);
        run_div(8'd239, 4'd15, lat, bm);      // largest in-range quotient
        check_result("u_239_15", lat, 4'd15, 4'd14, 1'b0, 1'b0);
        run_div(8'd240, 4'd15, lat, bm);      // quotient 16 overflows
        check_result("u_240_15", lat, 4'd0, 4'd0, 1'b1, 1'b0);
        run_div(8'd0, 4'd9, lat, bm);
        check_result("u_0_9", lat, 4'd0, 4'd0, 1'b0, 1'b0);
`endif

        run_div(8'd77, 4'd0, lat, bm);
        check_result("dbz_77_0", lat, 4'd0, 4'd0, 1'b0, 1'b1);

        // start held for 12 cycles; operands change while busy
        dividend = 8'd50;
        divisor  = 4'd7;
        start    = 1'b1;
        n_done   = 0;
        d1 = -1; d2 = -1;
        q1 = '0; r1 = '0; q2 = '0; r2 = '0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (c == 3) begin
                dividend = 8'd45;
                divisor  = 4'd6;
            end
            if (c == 12) start = 1'b0;
            if (c == 14) begin
                dividend = 8'd3;
                divisor  = 4'd1;
            end
            if (done) begin
                n_done++;
                if (n_done == 1) begin
                    d1 = c; q1 = quotient; r1 = remainder;
                end else if (n_done == 2) begin
                    d2 = c; q2 = quotient; r2 = remainder;
                end
            end
        end
        check("hs_count", n_done, 2);
        check("hs_done1", d1, 10);
        check("hs_done2", d2, 21);
        check("hs_res1", {24'd0, q1, r1}, {24'd0, 4'd7, 4'd1});
        check("hs_res2", {24'd0, q2, r2}, {24'd0, 4'd7, 4'd3});

        // reset in the middle of a division
        dividend  = 8'd50;
        divisor   = 4'd7;
        start     = 1'b1;
        seen_done = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            if (done) seen_done = 1'b1;
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (done) seen_done = 1'b1;
            if (c < 7) tick();
        end
        check("mid_rst_no_done", {31'd0, seen_done}, 32'd0);
        check("mid_rst_outs", {21'd0, busy, done, quotient, remainder, ovf, dbz}, 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        run_div(8'd50, 4'd7, lat, bm);
        check_result("post_rst", lat, 4'd7, 4'd1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
